// File: rtl/ipg_pkg.sv
// Shared constants for the IPG message inserter: 64b/66b idle encoding,
// sync headers and the bit layout of a tagged IPG block.
package ipg_pkg;

  localparam logic [7:0]  BTYPE_IDLE = 8'h1E;
  localparam logic [1:0]  SYNC_CTRL  = 2'b10;
  localparam logic [1:0]  SYNC_DATA  = 2'b01;
  localparam logic [63:0] IDLE_BLOCK = 64'h1E;

  // IPG block layout: {chunk[47:0], seq[3:0], ch[3:0], btype[7:0]}
  localparam int TAG_BTYPE_LSB = 0;
  localparam int TAG_CH_LSB    = 8;
  localparam int TAG_SEQ_LSB   = 12;
  localparam int TAG_CHUNK_LSB = 16;

  // Assemble a tagged IPG block from its fields.
  function automatic logic [63:0] build_ipg_block(
    input logic [47:0] chunk,
    input logic [3:0]  seq,
    input logic [3:0]  ch,
    input logic [7:0]  btype
  );
    logic [63:0] blk;
    blk = '0;
    blk[TAG_CHUNK_LSB +: 48] = chunk;
    blk[TAG_SEQ_LSB +: 4]    = seq;
    blk[TAG_CH_LSB +: 4]     = ch;
    blk[TAG_BTYPE_LSB +: 8]  = btype;
    return blk;
  endfunction

endpackage

// File: rtl/ipg_chunk_fifo.sv
// Per-channel synchronous chunk FIFO. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; the pop always returns the
// pre-existing head, so a push into an empty FIFO is not poppable that cycle.
module ipg_chunk_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ipg_tx_multi_inserter.sv
// Replaces all-idle 64b/66b control blocks with tagged IPG blocks carrying
// reply chunks from N_CH queues, round-robin, with a cap on consecutive
// replacements so genuine idles still reach the line.
//
// Handshake: in_valid is a one-cycle block strobe with no backpressure;
// every strobed block appears on out_* exactly one clock later with
// out_valid set. mem_write[i] is a push strobe; mem_full[i] is advisory and
// a push while full (without a same-cycle pop) is dropped and flagged.
module ipg_tx_multi_inserter
  import ipg_pkg::*;
#(
  parameter int         N_CH        = 4,
  parameter int         DEPTH       = 8,
  parameter int         CHUNK_WIDTH = 48,
  parameter logic [7:0] IPG_BTYPE   = 8'hA5,
  parameter int         MAX_BURST   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [63:0]             in_data,
  input  logic [1:0]              in_hdr,
  input  logic                    in_valid,
  input  logic                    ins_enable,
  input  logic [N_CH*CHUNK_WIDTH-1:0] mem_chunk,
  input  logic [N_CH-1:0]         mem_write,
  output logic [N_CH-1:0]         mem_full,
  output logic [N_CH-1:0]         mem_overflow,
  output logic [63:0]             out_data,
  output logic [1:0]              out_hdr,
  output logic                    out_valid,
  output logic                    ins_pulse
);

  localparam int BW = $clog2(MAX_BURST + 1);

  logic [CHUNK_WIDTH-1:0] heads [N_CH];
  logic [N_CH-1:0]        fifo_empty;
  logic [N_CH-1:0]        pop;
  logic [3:0]             seq [N_CH];
  logic [3:0]             rr_ptr;
  logic [BW-1:0]          burst_cnt;

  logic                   idle_slot;
  logic                   found;
  logic [3:0]             grant;
  logic [3:0]             next_rr;
  logic                   do_insert;
  logic [CHUNK_WIDTH-1:0] sel_chunk;
  logic [3:0]             sel_seq;
  int                     arb_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      ipg_chunk_fifo #(
        .DEPTH (DEPTH),
        .W     (CHUNK_WIDTH)
      ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (mem_write[gi]),
        .pop   (pop[gi]),
        .din   (mem_chunk[gi*CHUNK_WIDTH +: CHUNK_WIDTH]),
        .head  (heads[gi]),
        .full  (mem_full[gi]),
        .empty (fifo_empty[gi])
      );
    end
  endgenerate

  assign idle_slot = in_valid && (in_hdr == SYNC_CTRL) && (in_data == IDLE_BLOCK);

  // Round-robin grant: first non-empty channel at or after rr_ptr.
  always_comb begin
    found   = 1'b0;
    grant   = 4'd0;
    arb_idx = 0;
    for (int k = 0; k < N_CH; k++) begin
      arb_idx = (int'(rr_ptr) + k) % N_CH;
      if (!found && !fifo_empty[arb_idx]) begin
        found = 1'b1;
        grant = 4'(arb_idx);
      end
    end
  end

  assign do_insert = idle_slot && ins_enable && found && (burst_cnt < BW'(MAX_BURST));
  assign next_rr   = (grant == 4'(N_CH - 1)) ? 4'd0 : grant + 4'd1;

  // Pop strobes and the granted channel's head/sequence selection.
  always_comb begin
    pop       = '0;
    sel_chunk = '0;
    sel_seq   = 4'd0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == 4'(i)) begin
        sel_chunk = heads[i];
        sel_seq   = seq[i];
        pop[i]    = do_insert;
      end
    end
  end

  // Output register plus arbitration state; all frozen while in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= IDLE_BLOCK;
      out_hdr   <= SYNC_CTRL;
      out_valid <= 1'b0;
      ins_pulse <= 1'b0;
      rr_ptr    <= 4'd0;
      burst_cnt <= '0;
      for (int i = 0; i < N_CH; i++) seq[i] <= 4'd0;
    end else begin
      out_valid <= in_valid;
      ins_pulse <= 1'b0;
      if (in_valid) begin
        if (do_insert) begin
          out_data  <= build_ipg_block(sel_chunk, sel_seq, grant, IPG_BTYPE);
          out_hdr   <= SYNC_CTRL;
          ins_pulse <= 1'b1;
          rr_ptr    <= next_rr;
          burst_cnt <= burst_cnt + 1'b1;
          for (int i = 0; i < N_CH; i++) begin
            if (pop[i]) seq[i] <= seq[i] + 4'd1;
          end
        end else begin
          out_data  <= in_data;
          out_hdr   <= in_hdr;
          burst_cnt <= '0;
        end
      end
    end
  end

  // Sticky overflow: a push dropped because the FIFO was full and not popping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_overflow <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (mem_write[i] && mem_full[i] && !pop[i]) mem_overflow[i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ipg_tx_multi_inserter.sv
// Directed bench for ipg_tx_multi_inserter: stimulus pushes expected output
// words into exp_q, a negedge monitor pops and compares every out_valid beat.
module tb_ipg_tx_multi_inserter;

  localparam int N_CH = 4;
  localparam int CW   = 48;

  logic                 clk;
  logic                 rst_n;
  logic [63:0]          in_data;
  logic [1:0]           in_hdr;
  logic                 in_valid;
  logic                 ins_enable;
  logic [N_CH*CW-1:0]   mem_chunk;
  logic [N_CH-1:0]      mem_write;
  logic [N_CH-1:0]      mem_full;
  logic [N_CH-1:0]      mem_overflow;
  logic [63:0]          out_data;
  logic [1:0]           out_hdr;
  logic                 out_valid;
  logic                 ins_pulse;

  // {ins_pulse, out_hdr, out_data}
  logic [66:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] IDLE = 64'h1E;
  localparam logic [66:0] E_IDLE = {1'b0, 2'b10, 64'h1E};

  ipg_tx_multi_inserter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_hdr       (in_hdr),
    .in_valid     (in_valid),
    .ins_enable   (ins_enable),
    .mem_chunk    (mem_chunk),
    .mem_write    (mem_write),
    .mem_full     (mem_full),
    .mem_overflow (mem_overflow),
    .out_data     (out_data),
    .out_hdr      (out_hdr),
    .out_valid    (out_valid),
    .ins_pulse    (ins_pulse)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- expectation helpers ----------------
  function automatic logic [66:0] e_ipg(input logic [47:0] c, input logic [3:0] s,
                                        input logic [3:0] g);
    return {1'b1, 2'b10, c, s, g, 8'hA5};
  endfunction

  function automatic logic [66:0] e_pass(input logic [63:0] d, input logic [1:0] h);
    return {1'b0, h, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [63:0] d, input logic [1:0] h, input logic [66:0] e);
    in_data  = d;
    in_hdr   = h;
    in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input int ch, input logic [47:0] v);
    mem_write = '0;
    mem_write[ch] = 1'b1;
    mem_chunk[ch*CW +: CW] = v;
    @(posedge clk);
    #1;
    mem_write = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      logic [66:0] e;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got pulse=%b hdr=%b data=%h with no expected beat",
                 ins_pulse, out_hdr, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({ins_pulse, out_hdr, out_data} !== e) begin
          n_fail++;
          $display("FAIL out_beat: got pulse=%b hdr=%b data=%h expected pulse=%b hdr=%b data=%h",
                   ins_pulse, out_hdr, out_data, e[66], e[65:64], e[63:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [47:0] p [8];
    rst_n      = 1'b0;
    in_data    = '0;
    in_hdr     = 2'b00;
    in_valid   = 1'b0;
    ins_enable = 1'b1;
    mem_chunk  = '0;
    mem_write  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_data", out_data, IDLE);
    check("rst_out_hdr", 64'(out_hdr), 64'h2);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_ins_pulse", 64'(ins_pulse), 64'h0);
    check("rst_overflow", 64'(mem_overflow), 64'h0);
    rst_n = 1'b1;

    // Test 1: reset mid-insertion
    push(0, 48'h1111_2222_3333);
    push(0, 48'h4444_5555_6666);
    send(IDLE, 2'b10, e_ipg(48'h1111_2222_3333, 4'd0, 4'd0));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_data", out_data, IDLE);
    check("midrst_out_hdr", 64'(out_hdr), 64'h2);
    check("midrst_out_valid", 64'(out_valid), 64'h0);
    check("midrst_ins_pulse", 64'(ins_pulse), 64'h0);
    check("midrst_full", 64'(mem_full), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(IDLE, 2'b10, E_IDLE);   // FIFO ch0 emptied by reset

    // Test 2: single chunk on ch2
    push(2, 48'hA1B2C3D4E5F6);
    send(IDLE, 2'b10, {1'b1, 2'b10, 64'hA1B2C3D4E5F6_02_A5});
    send(IDLE, 2'b10, E_IDLE);   // FIFO now empty

    // Test 3: round-robin from rr_ptr=0
    do_reset();
    push(0, 48'hC0C0_0000_0000);
    push(1, 48'hC1C1_0000_0001);
    push(2, 48'hC2C2_0000_0002);
    push(3, 48'hC3C3_0000_0003);
    send(IDLE, 2'b10, {1'b1, 2'b10, 64'hC0C0_0000_0000_00_A5});
    send(IDLE, 2'b10, {1'b1, 2'b10, 64'hC1C1_0000_0001_01_A5});
    send(IDLE, 2'b10, {1'b1, 2'b10, 64'hC2C2_0000_0002_02_A5});
    send(IDLE, 2'b10, {1'b1, 2'b10, 64'hC3C3_0000_0003_03_A5});
    send(64'hDEAD_BEEF_0123_4567, 2'b01, e_pass(64'hDEAD_BEEF_0123_4567, 2'b01));
    push(3, 48'hD3D3_0000_0013);
    push(0, 48'hD0D0_0000_0010);
    // rr_ptr back at 0 -> ch0 first despite ch3 being pushed earlier
    send(IDLE, 2'b10, {1'b1, 2'b10, 64'hD0D0_0000_0010_10_A5});
    send(IDLE, 2'b10, {1'b1, 2'b10, 64'hD3D3_0000_0013_13_A5});

    // Test 4: burst cap
    do_reset();
    for (int k = 0; k < 6; k++) push(1, 48'hB000_0000_0000 + 48'(k));
    send(IDLE, 2'b10, {1'b1, 2'b10, 64'hB000_0000_0000_01_A5});
    send(IDLE, 2'b10, {1'b1, 2'b10, 64'hB000_0000_0001_11_A5});
    send(IDLE, 2'b10, {1'b1, 2'b10, 64'hB000_0000_0002_21_A5});
    send(IDLE, 2'b10, {1'b1, 2'b10, 64'hB000_0000_0003_31_A5});
    send(IDLE, 2'b10, E_IDLE);
    send(IDLE, 2'b10, {1'b1, 2'b10, 64'hB000_0000_0004_41_A5});
    send(64'h0123_4567_89AB_CDEF, 2'b01, e_pass(64'h0123_4567_89AB_CDEF, 2'b01));
    send(IDLE, 2'b10, {1'b1, 2'b10, 64'hB000_0000_0005_51_A5});

    // Test 5: non-idle blocks untouched, ins_enable gating
    do_reset();
    push(0, 48'h5A5A_5A5A_5A5A);
    send(64'hDEAD_BEEF_0123_4567, 2'b01, e_pass(64'hDEAD_BEEF_0123_4567, 2'b01));
    send(64'h5555_5555_5555_5578, 2'b10, e_pass(64'h5555_5555_5555_5578, 2'b10));
    send(64'h0000_0000_0000_011E, 2'b10, e_pass(64'h0000_0000_0000_011E, 2'b10));
    send(64'h0000_0000_0000_001E, 2'b01, e_pass(64'h0000_0000_0000_001E, 2'b01));
    ins_enable = 1'b0;
    send(IDLE, 2'b10, E_IDLE);
    ins_enable = 1'b1;
    send(IDLE, 2'b10, {1'b1, 2'b10, 64'h5A5A_5A5A_5A5A_00_A5});

    // Test 6: overflow then push with simultaneous pop
    do_reset();
    for (int k = 0; k < 8; k++) begin
      p[k] = 48'h3000_0000_0000 + 48'(k);
      push(3, p[k]);
    end
    check("full_after_8", 64'(mem_full), 64'h8);
    check("ovf_after_8", 64'(mem_overflow), 64'h0);
    push(3, 48'h3999_9999_9999);
    check("ovf_after_9", 64'(mem_overflow), 64'h8);
    check("full_after_9", 64'(mem_full), 64'h8);
    mem_write[3] = 1'b1;
    mem_chunk[3*CW +: CW] = 48'h3EEE_EEEE_EEEE;
    send(IDLE, 2'b10, {1'b1, 2'b10, 64'h3000_0000_0000_03_A5});
    mem_write = '0;
    check("full_after_pushpop", 64'(mem_full), 64'h8);
    for (int k = 1; k <= 8; k++) begin
      send(IDLE, 2'b10, e_ipg((k <= 7) ? p[k] : 48'h3EEE_EEEE_EEEE, 4'(k), 4'd3));
      send(64'hFACE_0000_0000_0001, 2'b01, e_pass(64'hFACE_0000_0000_0001, 2'b01));
      if (k == 1) check("full_after_drain1", 64'(mem_full), 64'h0);
    end
    send(IDLE, 2'b10, E_IDLE);
    check("ovf_sticky", 64'(mem_overflow), 64'h8);

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
